imem_fetch_responder: RTL and testbench

- Instruction-memory responder serving fetch requests issued by the program counter / fetch stage.
- Holds a word-addressed instruction store, returns instruction words in order after a fixed read latency, and buffers responses under decode backpressure.
- Its request-side ready is the stall source that gates PC write-enable.
- Sits between the PC and the decode stage; a load port fills the store before and during execution.

---
 rtl/imem_fetch_responder.sv | 129 ++++++++++++
 tb/tb_imem_fetch_responder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_responder.sv
// Instruction-memory fetch responder: word-addressed store, fixed-latency read pipeline
// and an in-order response queue, with credit-based request flow control.
module imem_fetch_responder #(
    parameter int AW      = 10,
    parameter int DW      = 32,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    input  logic [AW-1:0] req_addr,
    output logic          req_ready,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic [AW-1:0] rsp_addr,
    input  logic          rsp_ready,
    input  logic          flush,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Handshake: a transfer completes on a rising edge where valid and ready are both
    // high; a valid side holds its payload stable until that edge.
    logic          accept;
    logic          consume;
    logic          push;
    logic          run;
    logic [CW-1:0] occ;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    logic          pv [LATENCY];
    logic [AW-1:0] pa [LATENCY];
    logic [DW-1:0] pd [LATENCY];

    logic [DW-1:0] q_data [DEPTH];
    logic [AW-1:0] q_addr [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] q_cnt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credits are counted from registered occupancy, so a consume frees one a cycle later.
    assign req_ready = run & (occ < CW'(DEPTH)) & ~flush;
    assign rsp_valid = (q_cnt != '0) & ~flush;
    assign rsp_data  = q_data[rd_ptr];
    assign rsp_addr  = q_addr[rd_ptr];
    assign accept    = req_valid & req_ready;
    assign consume   = rsp_valid & rsp_ready;
    assign push      = pv[LATENCY-1] & ~flush;

    // The store is never reset; a same-edge read sees the old word.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run <= 1'b0;
            occ <= '0;
        end else begin
            run <= 1'b1;
            if (flush) begin
                occ <= '0;
            end else begin
                occ <= occ + CW'(accept) - CW'(consume);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                pv[i] <= 1'b0;
                pa[i] <= '0;
                pd[i] <= '0;
            end
        end else begin
            pv[0] <= accept;
            if (accept) begin
                pa[0] <= req_addr;
                pd[0] <= mem[req_addr];
            end
            for (int i = 1; i < LATENCY; i++) begin
                pv[i] <= pv[i-1] & ~flush;
                pa[i] <= pa[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end

    // Queue never overflows: total occupancy is bounded by DEPTH at accept time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_data[i] <= '0;
                q_addr[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            q_cnt  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            q_cnt  <= '0;
        end else begin
            if (push) begin
                q_data[wr_ptr] <= pd[LATENCY-1];
                q_addr[wr_ptr] <= pa[LATENCY-1];
                wr_ptr         <= ptr_inc(wr_ptr);
            end
            if (consume) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            q_cnt <= q_cnt + CW'(push) - CW'(consume);
        end
    end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Randomized and directed bench for imem_fetch_responder against a transaction-level
// model: a list of pending fetches, each visible once its latency has elapsed.
module tb_imem_fetch_responder;

    localparam int AW      = 10;
    localparam int DW      = 32;
    localparam int LATENCY = 2;
    localparam int DEPTH   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic [AW-1:0] req_addr;
    logic          req_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] rsp_addr;
    logic          rsp_ready;
    logic          flush;
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;

    imem_fetch_responder #(.AW(AW), .DW(DW), .LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_addr(rsp_addr),
        .rsp_ready(rsp_ready), .flush(flush),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            due;
    } fetch_t;

    fetch_t        exp_q[$];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            edge_n  = 0;
    bit            started = 0;
    int            errors  = 0;
    int            checks  = 0;
    int            accepts = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0;
        req_addr  = '0;
        flush     = 1'b0;
        ld_en     = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
    endtask

    // One clock: compare at the falling edge, then advance the model at the rising edge.
    task automatic cycle();
        bit m_ready;
        bit m_valid;
        fetch_t f;
        @(negedge clk);
        m_ready = rst && started && (exp_q.size() < DEPTH) && !flush;
        m_valid = rst && !flush && (exp_q.size() > 0) && (exp_q[0].due <= edge_n);
        check("req_ready", 64'(req_ready), 64'(m_ready));
        check("rsp_valid", 64'(rsp_valid), 64'(m_valid));
        if (m_valid) begin
            check("rsp_data", 64'(rsp_data), 64'(exp_q[0].d));
            check("rsp_addr", 64'(rsp_addr), 64'(exp_q[0].a));
        end
        @(posedge clk);
        if (rst) begin
            edge_n++;
            if (m_valid && rsp_ready) void'(exp_q.pop_front());
            if (req_valid && m_ready) begin
                f.a   = req_addr;
                f.d   = ref_mem[req_addr];
                f.due = edge_n + LATENCY;
                exp_q.push_back(f);
                accepts++;
            end
            if (ld_en) ref_mem[ld_addr] = ld_data;
            if (flush) exp_q.delete();
            started = 1;
        end else begin
            exp_q.delete();
            started = 0;
        end
        #1;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        cycle();
        ld_en = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        check("rst_rsp_addr", 64'(rsp_addr), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
    endtask

    int acc_before;

    initial begin
        rst = 1'b0;
        rsp_ready = 1'b1;
        idle_inputs();
        #2;
        check_reset_outputs();
        repeat (3) cycle();
        rst = 1'b1;
        cycle();

        // Preload the region the bench fetches from.
        for (int i = 0; i < 64; i++) begin
            if (i == 5)      load(AW'(i), 32'h8C22_0004);
            else if (i == 9) load(AW'(i), 32'h0);
            else             load(AW'(i), $urandom);
        end

        // Single fetch of addr 5.
        req_valid = 1'b1; req_addr = 5;
        cycle();
        req_valid = 1'b0;
        repeat (4) cycle();

        // Back-to-back 0..7 with decode always ready.
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1; req_addr = AW'(i);
            cycle();
        end
        req_valid = 1'b0;
        repeat (4) cycle();

        // Backpressure: only DEPTH requests get in, then drain in order.
        rsp_ready = 1'b0;
        acc_before = accepts;
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1; req_addr = AW'(16 + i);
            cycle();
        end
        check("bp_accepts", 64'(accepts - acc_before), 64'(DEPTH));
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1; req_addr = AW'(30 + i);
            cycle();
        end
        req_valid = 1'b0;
        repeat (6) cycle();

        // Flush with fetches in flight and queued.
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_addr = AW'(40 + i);
            cycle();
        end
        req_valid = 1'b0;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 20;
        cycle();
        req_valid = 1'b0;
        repeat (4) cycle();

        // Load/read collision on addr 9: old word first, new word on re-request.
        req_valid = 1'b1; req_addr = 9;
        ld_en = 1'b1; ld_addr = 9; ld_data = 32'h1234_5678;
        cycle();
        ld_en = 1'b0;
        cycle();
        req_valid = 1'b0;
        repeat (4) cycle();

        // Asynchronous reset with two fetches in flight.
        for (int i = 0; i < 2; i++) begin
            req_valid = 1'b1; req_addr = AW'(50 + i);
            cycle();
        end
        req_valid = 1'b0;
        #2 rst = 1'b0;
        #1 check_reset_outputs();
        repeat (2) cycle();
        rst = 1'b1;
        repeat (6) cycle();

        // Randomized traffic, loads and flushes.
        for (int n = 0; n < 600; n++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_addr  = AW'($urandom_range(0, 63));
            rsp_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            ld_en     = ($urandom_range(0, 3) == 0);
            ld_addr   = AW'($urandom_range(0, 63));
            ld_data   = $urandom;
            cycle();
        end
        idle_inputs();
        rsp_ready = 1'b1;
        repeat (10) cycle();
        check("drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
